// File: rtl/count_decoder.sv
// Recovers the target of an upstream ramp counter: after a load pulse the counter
// must climb 0,1,2,...,N and then repeat N for HOLD_CYC samples before N is reported.
module count_decoder #(
   parameter int unsigned HOLD_CYC = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_start,
   input  logic [4:0] in_cnt,
   output logic       out_valid,
   output logic [4:0] out_num,
   output logic       out_err,
   output logic       out_busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT0 = 2'd1,
      RAMP  = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [2:0] HOLD_LIM = 3'(HOLD_CYC);

   state_t     r_state;
   logic [4:0] r_prev;
   logic [2:0] r_hold;
   logic [4:0] r_num;
   logic       r_valid;
   logic       r_err;
   logic       r_busy;

   logic       w_inc;
   logic       w_same;
   logic [2:0] w_hold_inc;

   // Six-bit compare so that 31 followed by 0 is never taken as a step.
   assign w_inc      = ({1'b0, in_cnt} == ({1'b0, r_prev} + 6'd1));
   assign w_same     = (in_cnt == r_prev);
   assign w_hold_inc = r_hold + 3'd1;

   // Ramp-tracking FSM with registered pulse, target and busy outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_prev  <= 5'd0;
         r_hold  <= 3'd0;
         r_num   <= 5'd0;
         r_valid <= 1'b0;
         r_err   <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         r_err   <= 1'b0;
         if (in_start) begin
            r_state <= WAIT0;
            r_hold  <= 3'd0;
            r_busy  <= 1'b1;
         end else begin
            case (r_state)
               IDLE: begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end
               WAIT0: begin
                  if (in_cnt == 5'd0) begin
                     r_prev  <= 5'd0;
                     r_hold  <= 3'd0;
                     r_state <= RAMP;
                     r_busy  <= 1'b1;
                  end else begin
                     r_err   <= 1'b1;
                     r_state <= IDLE;
                     r_busy  <= 1'b0;
                  end
               end
               RAMP: begin
                  if (w_same) begin
                     r_hold <= w_hold_inc;
                     if (w_hold_inc == HOLD_LIM) begin
                        r_num   <= r_prev;
                        r_valid <= 1'b1;
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                     end else begin
                        r_state <= RAMP;
                        r_busy  <= 1'b1;
                     end
                  end else if (w_inc && (r_hold == 3'd0) && (r_prev != 5'd31)) begin
                     r_prev  <= in_cnt;
                     r_state <= RAMP;
                     r_busy  <= 1'b1;
                  end else begin
                     r_err   <= 1'b1;
                     r_state <= IDLE;
                     r_busy  <= 1'b0;
                  end
               end
               DONE: begin
                  if (in_cnt == r_num) begin
                     r_state <= DONE;
                     r_busy  <= 1'b0;
                  end else begin
                     r_err   <= 1'b1;
                     r_state <= IDLE;
                     r_busy  <= 1'b0;
                  end
               end
               default: begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign out_valid = r_valid;
   assign out_num   = r_num;
   assign out_err   = r_err;
   assign out_busy  = r_busy;

endmodule

// File: tb/tb_count_decoder.sv
// Directed bench for count_decoder: stimulus pushes expected pulses into a queue,
// a negedge monitor pops and compares whenever out_valid or out_err is seen.
module tb_count_decoder;

   logic       clk;
   logic       rst_n;
   logic       in_start;
   logic [4:0] in_cnt;
   logic       out_valid;
   logic [4:0] out_num;
   logic       out_err;
   logic       out_busy;

   typedef struct {
      bit         err;
      logic [4:0] num;
      int         cyc;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   count_decoder #(.HOLD_CYC(2)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_start (in_start),
      .in_cnt   (in_cnt),
      .out_valid(out_valid),
      .out_num  (out_num),
      .out_err  (out_err),
      .out_busy (out_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input bit err, input logic [4:0] num, input int at);
      exp_t e;
      e.err = err;
      e.num = num;
      e.cyc = at;
      q.push_back(e);
   endtask

   // Apply inputs for one cycle, then land just after the sampling edge.
   task automatic drive(input logic s, input logic [4:0] c);
      in_start = s;
      in_cnt   = c;
      @(posedge clk);
      #1;
   endtask

   task automatic run_ramp(input int n, input int reps);
      for (int i = 0; i <= n; i++) drive(1'b0, 5'(i));
      for (int r = 0; r < reps; r++) drive(1'b0, 5'(n));
   endtask

   task automatic settle(input logic [4:0] c, input int k);
      for (int i = 0; i < k; i++) drive(1'b0, c);
   endtask

   task automatic drained(input string name);
      chk(name, 32'(q.size()), 32'd0);
      q.delete();
   endtask

   // Scoreboard monitor: every output pulse must match the head of the queue.
   always @(negedge clk) begin
      if (out_valid || out_err) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse: got valid=%0d err=%0d num=%0d expected no pulse (cycle %0d)",
                     out_valid, out_err, out_num, cyc);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("pulse_err",   32'(out_err),   32'(e.err));
            chk("pulse_valid", 32'(out_valid), 32'(!e.err));
            chk("pulse_num",   32'(out_num),   32'(e.num));
            chk("pulse_cycle", 32'(cyc),       32'(e.cyc));
         end
      end
   end

   initial begin
      int b;
      rst_n    = 1'b0;
      in_start = 1'b0;
      in_cnt   = 5'd0;
      #12;
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_err",   32'(out_err),   32'd0);
      chk("rst_busy",  32'(out_busy),  32'd0);
      chk("rst_num",   32'(out_num),   32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      settle(5'd0, 2);

      // Ramp to 5 held twice, then leave DONE with a wrong value.
      b = cyc;
      push(1'b0, 5'd5, b + 9);
      drive(1'b1, 5'd0);
      chk("busy_wait0", 32'(out_busy), 32'd1);
      for (int i = 0; i <= 5; i++) begin
         drive(1'b0, 5'(i));
         chk("busy_ramp", 32'(out_busy), 32'd1);
      end
      drive(1'b0, 5'd5);
      chk("busy_hold", 32'(out_busy), 32'd1);
      drive(1'b0, 5'd5);
      drive(1'b0, 5'd5);
      chk("busy_done", 32'(out_busy), 32'd0);
      push(1'b1, 5'd5, cyc + 1);
      drive(1'b0, 5'd6);
      settle(5'd0, 2);
      drained("drain_n5");

      // Skipped step 0,1,3: error, back to IDLE, target retained.
      b = cyc;
      push(1'b1, 5'd5, b + 4);
      drive(1'b1, 5'd0);
      drive(1'b0, 5'd0);
      drive(1'b0, 5'd1);
      drive(1'b0, 5'd3);
      chk("busy_after_err", 32'(out_busy), 32'd0);
      settle(5'd0, 3);
      chk("idle_ignores_cnt", 32'(out_busy), 32'd0);
      drained("drain_skip");

      // Target 0: 0,0,0.
      b = cyc;
      push(1'b0, 5'd0, b + 4);
      drive(1'b1, 5'd0);
      run_ramp(0, 2);
      settle(5'd0, 3);
      drained("drain_n0");

      // Full ramp to 31 held twice.
      b = cyc;
      push(1'b0, 5'd31, b + 35);
      drive(1'b1, 5'd0);
      run_ramp(31, 2);
      settle(5'd31, 2);
      drained("drain_n31");

      // Ramp to 31 followed by 0 must not wrap.
      b = cyc;
      push(1'b1, 5'd31, b + 34);
      drive(1'b1, 5'd0);
      run_ramp(31, 0);
      drive(1'b0, 5'd0);
      settle(5'd0, 2);
      drained("drain_wrap");

      // Restart at cnt=3, then 0,1,2,2,2.
      drive(1'b1, 5'd0);
      for (int i = 0; i <= 3; i++) drive(1'b0, 5'(i));
      b = cyc;
      push(1'b0, 5'd2, b + 6);
      drive(1'b1, 5'd4);
      chk("busy_restart", 32'(out_busy), 32'd1);
      run_ramp(2, 2);
      settle(5'd2, 2);
      drained("drain_restart");

      // Asynchronous reset mid-ramp while cnt=4 is presented.
      drive(1'b1, 5'd0);
      for (int i = 0; i <= 3; i++) drive(1'b0, 5'(i));
      in_cnt = 5'd4;
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", 32'(out_valid), 32'd0);
      chk("arst_err",   32'(out_err),   32'd0);
      chk("arst_busy",  32'(out_busy),  32'd0);
      chk("arst_num",   32'(out_num),   32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      run_ramp(3, 3);
      chk("no_decode_without_start", 32'(out_busy), 32'd0);
      settle(5'd0, 2);
      drained("drain_reset");

      // Normal decode resumes after a fresh start.
      b = cyc;
      push(1'b0, 5'd1, b + 5);
      drive(1'b1, 5'd0);
      run_ramp(1, 2);
      settle(5'd1, 3);
      drained("drain_after_reset");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
